// File: rtl/rv_alu_arb.sv
// rv_alu_arb: round-robin arbiter sharing one combinational RV ALU between two
// requesters, with one registered response slot per port.
// Optional build macro: RV_ALU_ARB_STATS_EN adds a saturating conflict counter
// (parameter CNT_W, port o_conflict_cnt).
module rv_alu_arb
`ifdef RV_ALU_ARB_STATS_EN
#(
  parameter int unsigned CNT_W = 16
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  // port 0 request / response
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [3:0]  i_req0_op,
  input  logic [31:0] i_req0_a,
  input  logic [31:0] i_req0_b,
  output logic        o_rsp0_valid,
  input  logic        i_rsp0_ready,
  output logic [31:0] o_rsp0_data,
  output logic        o_rsp0_zero,
  // port 1 request / response
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [3:0]  i_req1_op,
  input  logic [31:0] i_req1_a,
  input  logic [31:0] i_req1_b,
  output logic        o_rsp1_valid,
  input  logic        i_rsp1_ready,
  output logic [31:0] o_rsp1_data,
  output logic        o_rsp1_zero,
  // shared ALU
  output logic [3:0]  o_alu_op,
  output logic [31:0] o_alu_rs1,
  output logic [31:0] o_alu_rs2,
  input  logic [31:0] i_alu_rd,
  input  logic        i_alu_zero
`ifdef RV_ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] o_conflict_cnt
`endif
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  slot_e       r_slot0;
  slot_e       r_slot1;
  slot_e       w_slot0_nxt;
  slot_e       w_slot1_nxt;
  logic        r_prio;
  logic [31:0] r_data0;
  logic [31:0] r_data1;
  logic        r_zero0;
  logic        r_zero1;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_gnt0;
  logic        w_gnt1;

  // A port may issue if it requests and its slot is empty or draining now.
  assign w_elig0 = i_req0_valid & ((r_slot0 == SLOT_EMPTY) | i_rsp0_ready);
  assign w_elig1 = i_req1_valid & ((r_slot1 == SLOT_EMPTY) | i_rsp1_ready);

  // Round-robin grant; held off while reset is asserted so ready reads 0 in reset.
  assign w_gnt0 = rst_n & w_elig0 & (~w_elig1 | ~r_prio);
  assign w_gnt1 = rst_n & w_elig1 & (~w_elig0 |  r_prio);

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;

  // Steer the granted port onto the ALU; port 0 when idle.
  always_comb begin
    o_alu_op  = i_req0_op;
    o_alu_rs1 = i_req0_a;
    o_alu_rs2 = i_req0_b;
    if (w_gnt1) begin
      o_alu_op  = i_req1_op;
      o_alu_rs1 = i_req1_a;
      o_alu_rs2 = i_req1_b;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot0 <= SLOT_EMPTY;
      r_slot1 <= SLOT_EMPTY;
    end else begin
      r_slot0 <= w_slot0_nxt;
      r_slot1 <= w_slot1_nxt;
    end
  end

  // Slot next state: capture wins over drain, drain alone empties the slot.
  always_comb begin
    w_slot0_nxt = r_slot0;
    w_slot1_nxt = r_slot1;
    if (w_gnt0) begin
      w_slot0_nxt = SLOT_FULL;
    end else if (i_rsp0_ready) begin
      w_slot0_nxt = SLOT_EMPTY;
    end
    if (w_gnt1) begin
      w_slot1_nxt = SLOT_FULL;
    end else if (i_rsp1_ready) begin
      w_slot1_nxt = SLOT_EMPTY;
    end
  end

  // Tie-break pointer: after a grant to port N the other port wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (w_gnt0) begin
      r_prio <= 1'b1;
    end else if (w_gnt1) begin
      r_prio <= 1'b0;
    end
  end

  // Capture the ALU result into the granted port's slot; data holds on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data0 <= 32'h0;
      r_zero0 <= 1'b0;
      r_data1 <= 32'h0;
      r_zero1 <= 1'b0;
    end else begin
      if (w_gnt0) begin
        r_data0 <= i_alu_rd;
        r_zero0 <= i_alu_zero;
      end
      if (w_gnt1) begin
        r_data1 <= i_alu_rd;
        r_zero1 <= i_alu_zero;
      end
    end
  end

  assign o_rsp0_valid = (r_slot0 == SLOT_FULL);
  assign o_rsp1_valid = (r_slot1 == SLOT_FULL);
  assign o_rsp0_data  = r_data0;
  assign o_rsp1_data  = r_data1;
  assign o_rsp0_zero  = r_zero0;
  assign o_rsp1_zero  = r_zero1;

`ifdef RV_ALU_ARB_STATS_EN
  logic [CNT_W-1:0] r_conflict_cnt;
  logic             w_conflict;

  // A conflict is a cycle where both request but only one is granted.
  assign w_conflict = i_req0_valid & i_req1_valid & (w_gnt0 ^ w_gnt1);

  // Saturating conflict counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != {CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: doc/rv_alu_arb.md
# rv_alu_arb

Two-port arbiter that time-shares the single combinational RV ALU between two requesters, for example the execute stage (port 0) and the branch/address unit (port 1). Each port gets a valid/ready request channel and a registered valid/ready response channel. Arbitration is round-robin, with one ALU operation per cycle. The ALU itself is instantiated outside this block and wired to its `alu_*` ports.

## Interface
- `CNT_W`, 16: width of the conflict counter (only present with `RV_ALU_ARB_STATS_EN`).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  request present on port 0 / port 1.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_op` / `req1_op`  in  4  ALU op code, `ALU_*` encodings from `rv_defs.v`.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  32  operands (rs1, rs2).
- `rsp0_valid` / `rsp1_valid`  out  1  result held in the port's response slot.
- `rsp0_ready` / `rsp1_ready`  in  1  consumer takes the result.
- `rsp0_data` / `rsp1_data`  out  32  registered ALU result.
- `rsp0_zero` / `rsp1_zero`  out  1  registered ALU `zero` flag.
- `alu_op`  out  4  op driven to the ALU.
- `alu_rs1`, `alu_rs2`  out  32  operands driven to the ALU.
- `alu_rd`  in  32  ALU result, combinational from `alu_*`.
- `alu_zero`  in  1  ALU zero flag.
- `conflict_cnt`  out  `CNT_W`  saturating conflict count (only with `RV_ALU_ARB_STATS_EN`).

## Operation
**Response slots**
- Each port has one response slot, with states EMPTY and FULL. `rspN_valid` is high exactly when the slot is FULL.
- Port N is eligible when `reqN_valid` is high and its slot can take a result: slot EMPTY, or FULL with `rspN_ready` high in the same cycle.

**Arbitration state**
- Register `prio`, 1 bit, naming the port that wins a tie. Reset value 0.
- Only one port eligible: that port is granted.
- Both ports eligible: port `prio` is granted.
- After any grant to port N, `prio` becomes !N. With no grant, `prio` holds.

**Grant path (combinational)**
- `reqN_ready` = grant to port N.
- `alu_op`, `alu_rs1`, `alu_rs2` are muxed from the granted port.
- With no grant they carry port 0's inputs. Their values are don't-care in that case.

**Capture**
- On a grant, `alu_rd` and `alu_zero` are written into slot N at the clock edge, and the slot becomes FULL.
- Drain and capture on the same slot in the same cycle leaves the slot FULL with the new data.
- Drain without capture makes the slot EMPTY. The data registers hold their old values.

**Other rules**
- A blocked port (slot FULL, no drain) never stalls the other port. There is no head-of-line blocking.
- The `zero` flag is meaningful only for SUB/SLT/SLTU. It is passed through untouched for every op.
- Requesters must hold op and operands stable while `valid` is high and `ready` is low. The arbiter does not check this.

## Timing
- Reset values: `reqN_ready` = 0, `rspN_valid` = 0, `rspN_data` = 0, `rspN_zero` = 0, `prio` = 0, `conflict_cnt` = 0.
- Reset is asynchronous and takes effect mid-operation: in-flight results are discarded and slots go EMPTY.
- Latency: a request accepted at edge E shows `rsp_valid` = 1 in the cycle after E.
- Throughput: 1 op per cycle in total. A single port with `rsp_ready` held high gets 1 op per cycle.
- Both ports continuously eligible: grants alternate 0,1,0,1,… starting from the current `prio`.

## Configuration
- `RV_ALU_ARB_STATS_EN` defined:
  - Adds port `conflict_cnt`.
  - The counter increments on every cycle where both `req0_valid` and `req1_valid` are high and only one is granted.
  - It saturates at all-ones.
- Undefined: the port and counter are absent, with no other behavioural difference.

## Test plan
- **Single-port ADD:** hold `req1_valid` low. Port 0 issues `ALU_ADD`, a=5, b=7 → `req0_ready` = 1 the same cycle, then `rsp0_valid` = 1 with `rsp0_data` = 12 on the next cycle.
- **Simultaneous after reset:** both ports request in the first cycle after reset. Port 0 `ALU_SUB` 9−9, port 1 `ALU_OR` 0xF0|0x0F.
  - Port 0 is granted first: `rsp0_data` = 0, `rsp0_zero` = 1.
  - Port 1 is granted next cycle: `rsp1_data` = 0xFF.
  - With stats enabled, `conflict_cnt` = 1.
- **Backpressure:** `rsp0_ready` = 0 with slot 0 FULL, and port 0 issues a new request → `req0_ready` stays 0. Port 1 `ALU_SLTU` 1<2 is granted and completes: `rsp1_data` = 1.
- **Drain plus capture:** `rsp0_ready` = 1 every cycle and port 0 streams `ALU_SLL` 1<<k for k = 0..3 → `rsp0_data` = 1, 2, 4, 8 on consecutive cycles. `rsp0_valid` never drops.
- **Reset mid-operation:** assert `rst_n` = 0 while slot 1 is FULL → `rsp1_valid` = 0 immediately, with no clock edge needed. After release, `prio` = 0.
- **Saturation (stats enabled, `CNT_W` = 4):** 20 consecutive contended cycles → `conflict_cnt` = 15 and stays there.
